// File: rtl/lsu_pkg.sv
// Shared constants, enums and decode helpers for the load/store sequencer.
package lsu_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    if (op == OP_LOAD) begin
      case (f3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
        default:                        ok = 1'b0;
      endcase
    end else if (op == OP_STORE) begin
      case (f3)
        F3_B, F3_H, F3_W: ok = 1'b1;
        default:          ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    case (f3)
      F3_H, F3_HU: mis = off[0];
      F3_W:        mis = (off != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Drops the low offset bits that a half/word access cannot use.
  function automatic logic [1:0] align_off(input logic [2:0] f3, input logic [1:0] off);
    logic [1:0] o;
    case (f3)
      F3_H, F3_HU: o = {off[1], 1'b0};
      F3_W:        o = 2'b00;
      default:     o = off;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store byte enables / replicated data and
// load lane extraction with sign or zero extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = 8'h00;
    case (off)
      2'd0: lane_b = rdata[7:0];
      2'd1: lane_b = rdata[15:8];
      2'd2: lane_b = rdata[23:16];
      2'd3: lane_b = rdata[31:24];
      default: lane_b = 8'h00;
    endcase
    lane_h = off[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    be        = 4'b0000;
    wdata_rep = wdata;
    rdata_ext = rdata;
    case (funct3)
      F3_B: begin
        be        = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{lane_b[7]}}, lane_b};
      end
      F3_H: begin
        be        = off[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{lane_h[15]}}, lane_h};
      end
      F3_W: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata;
      end
      F3_BU: rdata_ext = {24'h0, lane_b};
      F3_HU: rdata_ext = {16'h0, lane_h};
      default: begin
        be        = 4'b0000;
        rdata_ext = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between execute stage and data memory port.
// Optional build macro MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of aligning them.
//
// state  | meaning
// S_IDLE | ready for a new instruction (req_ready=1)
// S_REQ  | mem_req held, waiting for mem_ack or timeout
// S_RESP | one-cycle response strobe, then back to idle
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] inst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;

  logic [6:0]  in_op;
  logic [2:0]  in_f3;
  logic        in_store;
  logic        in_ok;
  logic [1:0]  in_off;
  logic [2:0]  f3_sel;
  logic [1:0]  off_sel;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] rdata_c;
  logic        unused_inst_bits;

  assign in_op            = inst[6:0];
  assign in_f3            = inst[14:12];
  assign in_store         = (in_op == OP_STORE);
  assign unused_inst_bits = &{1'b0, inst[31:15], inst[11:7]};

`ifdef MISALIGN_TRAP_EN
  assign in_ok  = is_legal(in_op, in_f3) && !is_misaligned(in_f3, addr[1:0]);
  assign in_off = addr[1:0];
`else
  assign in_ok  = is_legal(in_op, in_f3);
  assign in_off = align_off(in_f3, addr[1:0]);
`endif

  // The lane unit serves the live store operands in IDLE and the captured load lane afterwards.
  assign f3_sel  = (state == S_IDLE) ? in_f3  : f3_q;
  assign off_sel = (state == S_IDLE) ? in_off : off_q;

  lsu_lane_align u_align (
    .funct3    (f3_sel),
    .off       (off_sel),
    .wdata     (wdata),
    .rdata     (mem_rdata),
    .be        (be_c),
    .wdata_rep (wdata_c),
    .rdata_ext (rdata_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      f3_q      <= 3'b000;
      off_q     <= 2'b00;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'h0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_be    <= 4'b0000;
      mem_wdata <= 32'h0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'h0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (in_ok) begin
              state     <= S_REQ;
              cnt       <= '0;
              f3_q      <= in_f3;
              off_q     <= in_off;
              mem_req   <= 1'b1;
              mem_we    <= in_store;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_be    <= in_store ? be_c : 4'b0000;
              mem_wdata <= in_store ? wdata_c : 32'h0;
            end else begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (mem_ack || cnt == CNT_W'(TIMEOUT - 1)) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= !mem_ack;
            rsp_rdata <= (mem_ack && !mem_we) ? rdata_c : 32'h0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'b0000;
            mem_wdata <= 32'h0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_RESP: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed vector bench for lsu_ctrl (TIMEOUT=4), plus timeout and reset sequences.
module tb_lsu_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] inst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_pass  = 0;
  int n_total = 0;

  lsu_ctrl #(.TIMEOUT(TO), .CNT_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .inst      (inst),
    .addr      (addr),
    .wdata     (wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_dly;
    logic        exp_req;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
    return {17'h0, f3, 5'h0, op};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    chk({v.name, " req_ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; inst = v.inst; addr = v.addr; wdata = v.wdata;
    @(negedge clk);
    req_valid = 1'b0; inst = $urandom; addr = $urandom; wdata = $urandom;
    chk({v.name, " busy"}, 32'(busy), 32'd1);
    chk({v.name, " req_ready_busy"}, 32'(req_ready), 32'd0);
    if (v.exp_req) begin
      chk({v.name, " mem_req"}, 32'(mem_req), 32'd1);
      chk({v.name, " mem_we"}, 32'(mem_we), 32'(v.exp_we));
      chk({v.name, " mem_addr"}, mem_addr, v.exp_addr);
      chk({v.name, " mem_be"}, 32'(mem_be), 32'(v.exp_be));
      if (v.exp_we) chk({v.name, " mem_wdata"}, mem_wdata, v.exp_wdata);
      for (int k = 1; k < v.ack_dly; k++) begin
        @(negedge clk);
        chk({v.name, " mem_req_hold"}, 32'(mem_req), 32'd1);
        chk({v.name, " mem_addr_hold"}, mem_addr, v.exp_addr);
        chk({v.name, " no_early_rsp"}, 32'(rsp_valid), 32'd0);
      end
      mem_ack = 1'b1; mem_rdata = v.rdata;
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = $urandom;
    end else begin
      chk({v.name, " no_mem_req"}, 32'(mem_req), 32'd0);
    end
    chk({v.name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({v.name, " rsp_err"}, 32'(rsp_err), 32'(v.exp_err));
    chk({v.name, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
    chk({v.name, " mem_req_drop"}, 32'(mem_req), 32'd0);
    chk({v.name, " mem_be_idle"}, 32'(mem_be), 32'd0);
    @(negedge clk);
    chk({v.name, " rsp_pulse"}, 32'(rsp_valid), 32'd0);
    chk({v.name, " back_idle"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int req_cycles;
    reset = 1'b1; req_valid = 1'b0; inst = 32'h0; addr = 32'h0; wdata = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;

    //          name      inst              addr          wdata         rdata         dly req we  mem_addr      be       wdata         rsp_rdata     err
    vecs.push_back('{"lb",   mk(7'h03,3'd0), 32'h0000_1003, 32'h0,         32'h8012_3456, 3, 1, 0, 32'h0000_1000, 4'b0000, 32'h0,         32'hFFFF_FF80, 0});
    vecs.push_back('{"sh",   mk(7'h23,3'd1), 32'h0000_2002, 32'h1234_ABCD, 32'h5555_5555, 1, 1, 1, 32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 32'h0,         0});
    vecs.push_back('{"lhu",  mk(7'h03,3'd5), 32'h0000_0010, 32'h0,         32'h0000_F00D, 2, 1, 0, 32'h0000_0010, 4'b0000, 32'h0,         32'h0000_F00D, 0});
    vecs.push_back('{"lh",   mk(7'h03,3'd1), 32'h0000_0010, 32'h0,         32'h0000_F00D, 2, 1, 0, 32'h0000_0010, 4'b0000, 32'h0,         32'hFFFF_F00D, 0});
    vecs.push_back('{"lh_hi",mk(7'h03,3'd1), 32'h0000_0012, 32'h0,         32'h8001_7FFF, 1, 1, 0, 32'h0000_0010, 4'b0000, 32'h0,         32'hFFFF_8001, 0});
    vecs.push_back('{"sb",   mk(7'h23,3'd0), 32'h0000_3001, 32'hDEAD_BE5A, 32'h0,         1, 1, 1, 32'h0000_3000, 4'b0010, 32'h5A5A_5A5A, 32'h0,         0});
    vecs.push_back('{"lbu",  mk(7'h03,3'd4), 32'h0000_3002, 32'h0,         32'h11C5_2233, 2, 1, 0, 32'h0000_3000, 4'b0000, 32'h0,         32'h0000_00C5, 0});
    vecs.push_back('{"lw",   mk(7'h03,3'd2), 32'h0000_0044, 32'h0,         32'hCAFE_F00D, 1, 1, 0, 32'h0000_0044, 4'b0000, 32'h0,         32'hCAFE_F00D, 0});
    vecs.push_back('{"sw",   mk(7'h23,3'd2), 32'h0000_0048, 32'h0102_0304, 32'h0,         2, 1, 1, 32'h0000_0048, 4'b1111, 32'h0102_0304, 32'h0,         0});
    vecs.push_back('{"ack4", mk(7'h03,3'd2), 32'h0000_0080, 32'h0,         32'h7654_3210, TO,1, 0, 32'h0000_0080, 4'b0000, 32'h0,         32'h7654_3210, 0});
    vecs.push_back('{"ld011",mk(7'h03,3'd3), 32'h0000_0040, 32'h0,         32'h0,         1, 0, 0, 32'h0,         4'b0000, 32'h0,         32'h0,         1});
    vecs.push_back('{"op33", mk(7'h33,3'd0), 32'h0000_0040, 32'h0,         32'h0,         1, 0, 0, 32'h0,         4'b0000, 32'h0,         32'h0,         1});
    vecs.push_back('{"st100",mk(7'h23,3'd4), 32'h0000_0040, 32'h0,         32'h0,         1, 0, 0, 32'h0,         4'b0000, 32'h0,         32'h0,         1});
`ifdef MISALIGN_TRAP_EN
    vecs.push_back('{"lw6",  mk(7'h03,3'd2), 32'h0000_0006, 32'h0,         32'h89AB_CDEF, 1, 0, 0, 32'h0,         4'b0000, 32'h0,         32'h0,         1});
    vecs.push_back('{"sw6",  mk(7'h23,3'd2), 32'h0000_0006, 32'hA5A5_0F0F, 32'h0,         1, 0, 0, 32'h0,         4'b0000, 32'h0,         32'h0,         1});
    vecs.push_back('{"lhu3", mk(7'h03,3'd5), 32'h0000_0003, 32'h0,         32'h1234_8765, 1, 0, 0, 32'h0,         4'b0000, 32'h0,         32'h0,         1});
`else
    vecs.push_back('{"lw6",  mk(7'h03,3'd2), 32'h0000_0006, 32'h0,         32'h89AB_CDEF, 1, 1, 0, 32'h0000_0004, 4'b0000, 32'h0,         32'h89AB_CDEF, 0});
    vecs.push_back('{"sw6",  mk(7'h23,3'd2), 32'h0000_0006, 32'hA5A5_0F0F, 32'h0,         1, 1, 1, 32'h0000_0004, 4'b1111, 32'hA5A5_0F0F, 32'h0,         0});
    vecs.push_back('{"lhu3", mk(7'h03,3'd5), 32'h0000_0003, 32'h0,         32'h1234_8765, 1, 1, 0, 32'h0000_0000, 4'b0000, 32'h0,         32'h0000_1234, 0});
`endif

    repeat (2) @(negedge clk);
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst mem_be", 32'(mem_be), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    // Timeout: no ack, mem_req must stay up exactly TO cycles, then an error response.
    @(negedge clk);
    req_valid = 1'b1; inst = mk(7'h03, 3'd2); addr = 32'h0000_0100;
    @(negedge clk);
    req_valid = 1'b0;
    req_cycles = 0;
    for (int k = 0; k < 20 && mem_req; k++) begin
      req_cycles++;
      @(negedge clk);
    end
    chk("to req_cycles", 32'(req_cycles), 32'(TO));
    chk("to rsp_valid", 32'(rsp_valid), 32'd1);
    chk("to rsp_err", 32'(rsp_err), 32'd1);
    chk("to rsp_rdata", rsp_rdata, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("late_ack no_rsp", 32'(rsp_valid), 32'd0);
    chk("late_ack idle", 32'(req_ready), 32'd1);
    chk("late_ack no_req", 32'(mem_req), 32'd0);

    // Ack while idle is ignored.
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("idle_ack no_rsp", 32'(rsp_valid), 32'd0);
    chk("idle_ack busy", 32'(busy), 32'd0);

    // Reset in the middle of a request.
    req_valid = 1'b1; inst = mk(7'h03, 3'd2); addr = 32'h0000_0200;
    @(negedge clk);
    req_valid = 1'b0;
    chk("midrst mem_req_before", 32'(mem_req), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst mem_req", 32'(mem_req), 32'd0);
    chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst req_ready", 32'(req_ready), 32'd1);
    reset = 1'b0;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("midrst no_rsp_after", 32'(rsp_valid), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
